// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if -- handshake bundle for one pipeline stage register.
//   flush                  : synchronous kill of everything the stage holds
//   in_valid/in_ready/in_data    : upstream side (producer -> stage)
//   out_valid/out_ready/out_data : downstream side (stage -> consumer)
//   occupancy, stall_cnt   : status observed from the stage
// Modports:
//   slave  : the stage itself
//   master : the environment driving the stage (upstream + downstream + control)
interface pipe_skid_reg_if #(
  parameter int DATA_W = 256
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [31:0]       stall_cnt;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy, stall_cnt
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg -- pipeline stage register with optional two-entry skid buffer.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : pipe_skid_reg_if.slave (flush, in_* upstream handshake,
//          out_* downstream handshake, occupancy, stall_cnt)
// Parameters:
//   DATA_W       payload width
//   SKID         1: two entries, in_ready registered; 0: one entry, in_ready
//                combinational from out_ready
//   CLR_ON_FLUSH 1: flush zeroes stored payload; 0: flush drops valid only
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_EMPTY | no entry held, out_valid low
// ST_MAIN  | one entry in main, presented on out_data
// ST_BOTH  | main presented, second entry parked in skid (SKID=1)
module pipe_skid_reg #(
  parameter int DATA_W       = 256,
  parameter int SKID         = 1,
  parameter int CLR_ON_FLUSH = 1
) (
  input  logic           clk,
  input  logic           rst,
  pipe_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_BOTH  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        occ_q, occ_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic out_valid;
  logic in_ready;
  logic in_fire;
  logic out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  // With SKID=0 the single entry can be replaced in the same cycle it leaves,
  // so readiness must follow out_ready combinationally.
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || bus.out_ready);
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (bus.flush) begin
      // A same-cycle out_fire is treated as consumed; in_fire is dropped.
      state_d = ST_EMPTY;
      if (CLR_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_MAIN;
            main_d  = bus.in_data;
          end
        end
        ST_MAIN: begin
          if (in_fire && out_fire) begin
            main_d = bus.in_data;
          end else if (in_fire) begin
            // Only reachable with SKID=1; SKID=0 in_ready implies out_fire here.
            state_d = ST_BOTH;
            skid_d  = bus.in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_BOTH: begin
          if (out_fire) begin
            state_d = ST_MAIN;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready_d  = (state_d != ST_BOTH);
    occ_d       = state_d;
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      occ_q       <= occ_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q;
  assign bus.occupancy = occ_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg -- directed bench for pipe_skid_reg.
// Instance dut uses SKID=1, instance dut0 uses SKID=0; both CLR_ON_FLUSH=1.
module tb_pipe_skid_reg;
  localparam int DW = 16;

  logic clk;
  logic rst;

  pipe_skid_reg_if #(.DATA_W(DW)) a ();
  pipe_skid_reg_if #(.DATA_W(DW)) b ();

  pipe_skid_reg #(.DATA_W(DW), .SKID(1), .CLR_ON_FLUSH(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  pipe_skid_reg #(.DATA_W(DW), .SKID(0), .CLR_ON_FLUSH(1)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  int n_chk;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [DW-1:0] d, input logic rdy, input logic fl);
    a.in_valid  = v;
    a.in_data   = d;
    a.out_ready = rdy;
    a.flush     = fl;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    drive_a(1'b0, '0, 1'b0, 1'b0);
    b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0; b.flush = 1'b0;

    // reset state
    #2;
    check("rst_out_valid", 32'(a.out_valid), 32'd0);
    check("rst_occ",       32'(a.occupancy), 32'd0);
    check("rst_stall",     a.stall_cnt,      32'd0);
    check("rst_data",      32'(a.out_data),  32'd0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", 32'(a.in_ready), 32'd1);

    // stream 1..4 at full throughput
    drive_a(1'b1, 16'd1, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("stream_valid", 32'(a.out_valid), 32'd1);
      check("stream_data",  32'(a.out_data),  32'(i));
      check("stream_occ",   32'(a.occupancy), 32'd1);
      a.in_data = 16'(i + 1);
    end
    a.in_valid = 1'b0;
    step();
    check("stream_drain", 32'(a.out_valid), 32'd0);
    check("stream_stall", a.stall_cnt, 32'd0);

    // backpressure: A, B held, C offered while full
    drive_a(1'b1, 16'h00AA, 1'b0, 1'b0);
    step();
    check("bp_occ1",   32'(a.occupancy), 32'd1);
    check("bp_rdy1",   32'(a.in_ready),  32'd1);
    a.in_data = 16'h00BB;
    step();
    check("bp_occ2",   32'(a.occupancy), 32'd2);
    check("bp_rdy2",   32'(a.in_ready),  32'd0);
    check("bp_stall1", a.stall_cnt,      32'd1);
    a.in_data = 16'h00DD;
    step();
    check("bp_hold_data", 32'(a.out_data), 32'h00AA);
    check("bp_stall2",    a.stall_cnt,     32'd2);
    drive_a(1'b0, '0, 1'b1, 1'b0);
    step();
    check("bp_dataB",  32'(a.out_data),  32'h00BB);
    check("bp_rdy3",   32'(a.in_ready),  32'd1);
    check("bp_occ3",   32'(a.occupancy), 32'd1);
    check("bp_stall3", a.stall_cnt,      32'd2);
    step();
    check("bp_empty",  32'(a.out_valid), 32'd0);

    // flush collision in BOTH
    drive_a(1'b1, 16'h00A1, 1'b0, 1'b0);
    step();
    a.in_data = 16'h00B2;
    step();
    check("fl_both", 32'(a.occupancy), 32'd2);
    drive_a(1'b1, 16'h00C3, 1'b0, 1'b1);
    step();
    check("fl_valid",  32'(a.out_valid),  32'd0);
    check("fl_occ",    32'(a.occupancy),  32'd0);
    check("fl_data",   32'(a.out_data),   32'd0);
    check("fl_skid",   32'(dut.skid_q),   32'd0);
    check("fl_rdy",    32'(a.in_ready),   32'd1);
    check("fl_stall",  a.stall_cnt,       32'd4);
    drive_a(1'b0, '0, 1'b1, 1'b0);
    step();
    check("fl_no_c", 32'(a.out_valid), 32'd0);

    // flush in MAIN discards a same-cycle accepted entry
    drive_a(1'b1, 16'h0055, 1'b0, 1'b0);
    step();
    drive_a(1'b1, 16'h0066, 1'b0, 1'b1);
    step();
    check("flm_valid", 32'(a.out_valid), 32'd0);
    drive_a(1'b0, '0, 1'b1, 1'b0);
    step();
    check("flm_no_y",  32'(a.out_valid), 32'd0);
    check("flm_stall", a.stall_cnt,      32'd5);

    // async reset between edges while BOTH
    drive_a(1'b1, 16'h0011, 1'b0, 1'b0);
    step();
    a.in_data = 16'h0022;
    step();
    check("ar_both",  32'(a.occupancy), 32'd2);
    check("ar_stall", a.stall_cnt,      32'd6);
    drive_a(1'b0, '0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(a.out_valid), 32'd0);
    check("ar_occ",   32'(a.occupancy), 32'd0);
    check("ar_stall0", a.stall_cnt,     32'd0);
    check("ar_data",  32'(a.out_data),  32'd0);
    rst = 1'b0;
    step();
    check("ar_rdy",    32'(a.in_ready),  32'd1);
    check("ar_valid2", 32'(a.out_valid), 32'd0);

    // stall counter saturation
    drive_a(1'b1, 16'h0077, 1'b0, 1'b0);
    step();
    a.in_valid = 1'b0;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    step();
    release dut.stall_cnt_q;
    step();
    step();
    check("sat_max",  a.stall_cnt, 32'hFFFF_FFFF);
    step();
    check("sat_hold", a.stall_cnt, 32'hFFFF_FFFF);
    drive_a(1'b0, '0, 1'b1, 1'b0);
    step();

    // SKID=0: combinational in_ready, replace on simultaneous fire
    b.in_valid = 1'b1; b.in_data = 16'h0031; b.out_ready = 1'b0;
    #1;
    check("s0_rdy_empty", 32'(b.in_ready), 32'd1);
    step();
    check("s0_valid", 32'(b.out_valid), 32'd1);
    check("s0_data1", 32'(b.out_data),  32'h0031);
    b.in_data = 16'h0032;
    #1;
    check("s0_rdy_block", 32'(b.in_ready), 32'd0);
    step();
    check("s0_hold", 32'(b.out_data),  32'h0031);
    check("s0_occ",  32'(b.occupancy), 32'd1);
    b.out_ready = 1'b1;
    #1;
    check("s0_rdy_pass", 32'(b.in_ready), 32'd1);
    step();
    check("s0_valid2", 32'(b.out_valid), 32'd1);
    check("s0_data2",  32'(b.out_data),  32'h0032);
    check("s0_occ2",   32'(b.occupancy), 32'd1);
    b.in_valid = 1'b0;
    step();
    check("s0_empty", 32'(b.out_valid), 32'd0);
    check("s0_stall", b.stall_cnt,      32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 256, payload width in bits (bundle of pc, inst, decode, operands, CSR fields).
REQ-002 Parameter SKID, default 1: 1 = two-entry skid buffer (registered in_ready); 0 = single entry, combinational in_ready.
REQ-003 Parameter CLR_ON_FLUSH, default 1: 1 = flush zeroes stored payload; 0 = flush clears valid only.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous kill of all held and incoming entries.
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_ready  output  1  stage accepts in_data this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  out_data valid for downstream.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 out_data  output  DATA_W  payload at head of stage.
REQ-013 occupancy  output  2  entries held (0..2; max 1 when SKID=0).
REQ-014 stall_cnt  output  32  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; payload moves only on fire.
REQ-016 Order preserved; no entry dropped or duplicated except by flush or rst.
REQ-017 SKID=1 state machine: EMPTY (0 entries), MAIN (1), BOTH (2); out_data always from main entry.
REQ-018 EMPTY: in_fire -> MAIN, main <= in_data; otherwise stay.
REQ-019 MAIN: in_fire & !out_fire -> BOTH, skid <= in_data; !in_fire & out_fire -> EMPTY; in_fire & out_fire -> MAIN, main <= in_data.
REQ-020 BOTH: out_fire -> MAIN, main <= skid; in_ready=0 so no in_fire.
REQ-021 SKID=1: in_ready = (state != BOTH), driven from a flop, no combinational path from out_ready.
REQ-022 SKID=0: in_ready = !out_valid | out_ready (combinational); single entry; simultaneous fire replaces entry.
REQ-023 out_valid = (state != EMPTY); latency in_fire to out_valid = 1 cycle; full throughput of 1 transfer/cycle with out_ready held high.
REQ-024 flush: next state EMPTY regardless of in_valid, out_ready or current state; in_fire that cycle discarded; out_fire that cycle counts as consumed downstream.
REQ-025 flush with CLR_ON_FLUSH=1 zeroes main and skid payload; with 0, payload retained but not presented as valid.
REQ-026 occupancy = 0/1/2 for EMPTY/MAIN/BOTH, registered.
REQ-027 stall_cnt increments by 1 each cycle out_valid & !out_ready, saturates at 0xFFFFFFFF, unaffected by flush.

Reset
REQ-028 rst asserted: state EMPTY, out_valid=0, out_data=0, occupancy=0, stall_cnt=0, skid payload=0, immediately without clk.
REQ-029 In-flight entries discarded on rst mid-operation; in_ready=1 on the first edge after rst deasserts (SKID=1); inputs ignored while rst=1.

Verification
REQ-030 Stream: SKID=1, out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, out_valid continuous, occupancy=1.
REQ-031 Backpressure: load A, B while out_ready=0 -> occupancy=2, in_ready=0, stall_cnt increments per cycle; raise out_ready -> A then B, in_ready=1 after A leaves.
REQ-032 Flush collision: state BOTH, flush=1 with in_valid=1 data C -> next cycle out_valid=0, occupancy=0, C never appears, payload=0 (CLR_ON_FLUSH=1).
REQ-033 SKID=0: out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> in_ready=1, entry replaced, out_valid stays 1.
REQ-034 Async reset mid-stream: state BOTH, rst pulse between edges -> out_valid=0, occupancy=0, stall_cnt=0 before next edge.
REQ-035 Saturation: force stall_cnt to 0xFFFFFFFE, hold out_valid=1, out_ready=0 for 3 cycles -> stall_cnt reads 0xFFFFFFFF, no wrap.
